// File: rtl/conv_packet_feeder_pkg.sv
// Shared widths and FSM state encoding for the convolution packet feeder.
package conv_packet_feeder_pkg;

  localparam int PIX_W  = 8;
  localparam int KERN_W = 36;
  localparam int RES_W  = 32;
  localparam int WIN_N  = 9;
  localparam int PKT_W  = KERN_W + WIN_N * PIX_W;
  localparam int CNT_W  = $clog2(WIN_N);
  localparam int SLOT_W = $clog2(WIN_N - 1);

  typedef enum logic [2:0] {
    ST_COLLECT,
    ST_SEND,
    ST_WAIT_RES,
    ST_RELEASE,
    ST_OUTPUT
  } state_t;

endpackage

// File: rtl/conv_window_packer.sv
// Collects a 3x3 pixel window in raster order and latches it with the kernel
// into one packet on the ninth beat.
module conv_window_packer
  import conv_packet_feeder_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              i_en,
  input  logic              i_valid,
  input  logic [PIX_W-1:0]  i_pix,
  input  logic [KERN_W-1:0] i_kernel,
  output logic              o_last,
  output logic [PKT_W-1:0]  o_packet
);

  logic [PIX_W-1:0]       r_slot [WIN_N-1];
  logic [CNT_W-1:0]       r_cnt;
  logic [PKT_W-1:0]       r_packet;
  logic                   w_beat;
  logic [WIN_N*PIX_W-1:0] w_window;

  assign w_beat   = i_en & i_valid;
  assign o_last   = w_beat && (r_cnt == CNT_W'(WIN_N - 1));
  assign o_packet = r_packet;

  // The ninth pixel is taken straight from the input, so only eight slots exist.
  always_comb begin
    w_window = '0;
    for (int i = 0; i < WIN_N - 1; i++)
      w_window[(WIN_N-1-i)*PIX_W +: PIX_W] = r_slot[i];
    w_window[PIX_W-1:0] = i_pix;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt    <= '0;
      r_packet <= '0;
      for (int i = 0; i < WIN_N - 1; i++)
        r_slot[i] <= '0;
    end else if (w_beat) begin
      if (o_last) begin
        r_cnt    <= '0;
        r_packet <= {i_kernel, w_window};
      end else begin
        r_slot[r_cnt[SLOT_W-1:0]] <= i_pix;
        r_cnt                     <= r_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/conv_packet_feeder.sv
// Sequences pixel windows to a convolution accelerator and returns its result,
// aborting with a sticky error if the accelerator stalls too long.
//
// state       | meaning
// ST_COLLECT  | accepting pixels; ninth beat latches the packet
// ST_SEND     | offering packet; acc_valid follows acc_ready until it drops
// ST_WAIT_RES | acc_target_ready high, waiting for acc_res_valid
// ST_RELEASE  | waiting for the accelerator to drop acc_res_valid
// ST_OUTPUT   | presenting res_data until res_ready
module conv_packet_feeder
  import conv_packet_feeder_pkg::*;
#(
  parameter int TIMEOUT_CYC = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              kernel_load,
  input  logic [KERN_W-1:0] kernel_in,
  input  logic              pix_valid,
  output logic              pix_ready,
  input  logic [PIX_W-1:0]  pix_data,
  input  logic              acc_ready,
  output logic              acc_valid,
  output logic [PKT_W-1:0]  acc_data,
  input  logic              acc_res_valid,
  output logic              acc_target_ready,
  input  logic [RES_W-1:0]  acc_res_data,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [RES_W-1:0]  res_data,
  output logic              err
);

  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);

  state_t            r_state;
  state_t            w_next;
  logic [KERN_W-1:0] r_kernel;
  logic              r_acc_valid;
  logic [RES_W-1:0]  r_res_data;
  logic              r_err;
  logic [TMO_W-1:0]  r_tmo;
  logic              w_last;
  logic              w_tmo_hit;
  logic              w_timed;

  conv_window_packer u_packer (
    .clk      (clk),
    .rst      (rst),
    .i_en     (pix_ready),
    .i_valid  (pix_valid),
    .i_pix    (pix_data),
    .i_kernel (r_kernel),
    .o_last   (w_last),
    .o_packet (acc_data)
  );

  assign w_timed   = (r_state == ST_SEND) || (r_state == ST_WAIT_RES);
  assign w_tmo_hit = w_timed && (r_tmo == '0);

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_COLLECT:  if (w_last) w_next = ST_SEND;
      ST_SEND: begin
        if (w_tmo_hit)                    w_next = ST_COLLECT;
        else if (r_acc_valid && !acc_ready) w_next = ST_WAIT_RES;
      end
      ST_WAIT_RES: begin
        if (w_tmo_hit)          w_next = ST_COLLECT;
        else if (acc_res_valid) w_next = ST_RELEASE;
      end
      ST_RELEASE:  if (!acc_res_valid) w_next = ST_OUTPUT;
      ST_OUTPUT:   if (res_ready) w_next = ST_COLLECT;
      default:     w_next = ST_COLLECT;
    endcase
  end

  // Timeout down-counter reloads on each entry to a timed state; abort at zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_COLLECT;
      r_kernel    <= '0;
      r_acc_valid <= 1'b0;
      r_res_data  <= '0;
      r_err       <= 1'b0;
      r_tmo       <= '0;
    end else begin
      r_state     <= w_next;
      r_acc_valid <= (r_state == ST_SEND) && (w_next == ST_SEND) &&
                     (r_acc_valid || acc_ready);
      if (kernel_load)
        r_kernel <= kernel_in;
      if (w_tmo_hit)
        r_err <= 1'b1;
      if ((r_state == ST_WAIT_RES) && acc_res_valid && !w_tmo_hit)
        r_res_data <= acc_res_data;
      if ((w_next != r_state) && ((w_next == ST_SEND) || (w_next == ST_WAIT_RES)))
        r_tmo <= TMO_W'(TIMEOUT_CYC - 1);
      else if (r_tmo != '0)
        r_tmo <= r_tmo - 1'b1;
    end
  end

  assign pix_ready        = (r_state == ST_COLLECT);
  assign acc_target_ready = (r_state == ST_WAIT_RES);
  assign res_valid        = (r_state == ST_OUTPUT);
  assign acc_valid        = r_acc_valid;
  assign res_data         = r_res_data;
  assign err              = r_err;

endmodule

// File: tb/tb_conv_packet_feeder.sv
// Directed bench for conv_packet_feeder with a simple accelerator peer model.
module tb_conv_packet_feeder;

  logic          clk;
  logic          rst;
  logic          kernel_load;
  logic [35:0]   kernel_in;
  logic          pix_valid;
  logic          pix_ready;
  logic [7:0]    pix_data;
  logic          acc_ready;
  logic          acc_valid;
  logic [107:0]  acc_data;
  logic          acc_res_valid;
  logic          acc_target_ready;
  logic [31:0]   acc_res_data;
  logic          res_valid;
  logic          res_ready;
  logic [31:0]   res_data;
  logic          err;

  logic acc_en;
  logic res_en;
  int   checks;
  int   errors;

  conv_packet_feeder #(.TIMEOUT_CYC(255)) dut (
    .clk              (clk),
    .rst              (rst),
    .kernel_load      (kernel_load),
    .kernel_in        (kernel_in),
    .pix_valid        (pix_valid),
    .pix_ready        (pix_ready),
    .pix_data         (pix_data),
    .acc_ready        (acc_ready),
    .acc_valid        (acc_valid),
    .acc_data         (acc_data),
    .acc_res_valid    (acc_res_valid),
    .acc_target_ready (acc_target_ready),
    .acc_res_data     (acc_res_data),
    .res_valid        (res_valid),
    .res_ready        (res_ready),
    .res_data         (res_data),
    .err              (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Accelerator peer: ready until the packet is offered, answers immediately.
  function automatic logic [31:0] mac(input logic [107:0] p);
    logic [31:0] s;
    s = 32'd0;
    for (int i = 0; i < 9; i++)
      s = s + 32'(p[104-4*i +: 4]) * 32'(p[64-8*i +: 8]);
    return s;
  endfunction

  assign acc_ready     = acc_en & ~acc_valid;
  assign acc_res_valid = res_en & acc_target_ready;
  assign acc_res_data  = mac(acc_data);

  task automatic send_window(input logic [71:0] px, input logic load_last,
                             input logic [35:0] new_k);
    int w;
    w = 0;
    @(negedge clk);
    while (!pix_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    checks++;
    if (pix_ready !== 1'b1) begin
      errors++;
      $display("FAIL win_ready: pix_ready=%b expected 1", pix_ready);
    end
    for (int i = 0; i < 9; i++) begin
      if (i > 0) @(negedge clk);
      pix_valid = 1'b1;
      pix_data  = px[(8-i)*8 +: 8];
      if (i == 8 && load_last) begin
        kernel_load = 1'b1;
        kernel_in   = new_k;
      end
    end
    @(negedge clk);
    pix_valid   = 1'b0;
    kernel_load = 1'b0;
  endtask

  task automatic wait_res(output int lat);
    lat = 0;
    while (!res_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic load_kernel(input logic [35:0] k);
    @(negedge clk);
    kernel_load = 1'b1;
    kernel_in   = k;
    @(negedge clk);
    kernel_load = 1'b0;
  endtask

  task automatic drain_res();
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({pix_ready, acc_valid, acc_target_ready, res_valid, err} !== 5'b10000) begin
      errors++;
      $display("FAIL reset_ctrl: got %b expected 10000",
               {pix_ready, acc_valid, acc_target_ready, res_valid, err});
    end
    checks++;
    if (res_data !== 32'd0 || acc_data !== 108'd0) begin
      errors++;
      $display("FAIL reset_data: res_data=%0h acc_data=%0h expected 0", res_data, acc_data);
    end
  endtask

  task automatic test_basic();
    int lat;
    acc_en = 1'b1; res_en = 1'b1; res_ready = 1'b0;
    load_kernel(36'h111111111);
    send_window(72'h010203040506070809, 1'b0, 36'h0);
    checks++;
    if (acc_data !== {36'h111111111, 72'h010203040506070809}) begin
      errors++;
      $display("FAIL basic_packet: got %h expected 111111111010203040506070809", acc_data);
    end
    checks++;
    if (pix_ready !== 1'b0) begin
      errors++;
      $display("FAIL basic_pix_ready: got %b expected 0", pix_ready);
    end
    wait_res(lat);
    checks++;
    if (res_valid !== 1'b1 || lat + 1 != 5) begin
      errors++;
      $display("FAIL basic_latency: res_valid=%b latency=%0d expected 1 and 5", res_valid, lat + 1);
    end
    checks++;
    if (res_data !== 32'd45) begin
      errors++;
      $display("FAIL basic_result: got %0d expected 45", res_data);
    end
    drain_res();
    checks++;
    if (res_valid !== 1'b0 || pix_ready !== 1'b1) begin
      errors++;
      $display("FAIL basic_return: res_valid=%b pix_ready=%b expected 0 1", res_valid, pix_ready);
    end
  endtask

  task automatic test_backpressure();
    int lat;
    load_kernel(36'hFFFFFFFFF);
    send_window({9{8'hFF}}, 1'b0, 36'h0);
    wait_res(lat);
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (res_valid !== 1'b1 || res_data !== 32'd34425) begin
        errors++;
        $display("FAIL hold_res[%0d]: res_valid=%b res_data=%0d expected 1 34425", i, res_valid, res_data);
      end
      @(negedge clk);
    end
    drain_res();
    checks++;
    if (pix_ready !== 1'b1) begin
      errors++;
      $display("FAIL hold_return: pix_ready=%b expected 1", pix_ready);
    end
  endtask

  task automatic test_kernel_same_cycle();
    int lat;
    send_window(72'h010203040506070809, 1'b1, 36'h123456789);
    checks++;
    if (acc_data[107:72] !== 36'hFFFFFFFFF) begin
      errors++;
      $display("FAIL kload_old: got %h expected FFFFFFFFF", acc_data[107:72]);
    end
    wait_res(lat);
    checks++;
    if (res_data !== 32'd675) begin
      errors++;
      $display("FAIL kload_old_res: got %0d expected 675", res_data);
    end
    drain_res();
    send_window(72'h010203040506070809, 1'b0, 36'h0);
    checks++;
    if (acc_data[107:72] !== 36'h123456789) begin
      errors++;
      $display("FAIL kload_new: got %h expected 123456789", acc_data[107:72]);
    end
    wait_res(lat);
    checks++;
    if (res_data !== 32'd285) begin
      errors++;
      $display("FAIL kload_new_res: got %0d expected 285", res_data);
    end
    drain_res();
  endtask

  task automatic test_timeout();
    acc_en = 1'b0;
    send_window(72'h090807060504030201, 1'b0, 36'h0);
    repeat (254) @(negedge clk);
    checks++;
    if (err !== 1'b0 || pix_ready !== 1'b0 || acc_valid !== 1'b0) begin
      errors++;
      $display("FAIL tmo_early: err=%b pix_ready=%b acc_valid=%b expected 0 0 0", err, pix_ready, acc_valid);
    end
    @(negedge clk);
    checks++;
    if (err !== 1'b1 || pix_ready !== 1'b1) begin
      errors++;
      $display("FAIL tmo_fire: err=%b pix_ready=%b expected 1 1", err, pix_ready);
    end
    checks++;
    if (res_data !== 32'd285) begin
      errors++;
      $display("FAIL tmo_res_kept: got %0d expected 285", res_data);
    end
    repeat (45) @(negedge clk);
    checks++;
    if (err !== 1'b1 || pix_ready !== 1'b1 || acc_valid !== 1'b0) begin
      errors++;
      $display("FAIL tmo_sticky: err=%b pix_ready=%b acc_valid=%b expected 1 1 0", err, pix_ready, acc_valid);
    end
    acc_en = 1'b1;
  endtask

  task automatic test_rst_mid();
    int w;
    res_en = 1'b0;
    send_window(72'h111213141516171819, 1'b0, 36'h0);
    w = 0;
    while (!acc_target_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    checks++;
    if (acc_target_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_reach_wait: acc_target_ready=%b expected 1", acc_target_ready);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (acc_target_ready !== 1'b0 || acc_valid !== 1'b0 || err !== 1'b0 || res_data !== 32'd0) begin
      errors++;
      $display("FAIL rst_immediate: tready=%b avalid=%b err=%b res=%0d expected 0 0 0 0",
               acc_target_ready, acc_valid, err, res_data);
    end
    @(negedge clk);
    rst = 1'b0;
    res_en = 1'b1;
    send_window(72'h0A0B0C0D0E0F101112, 1'b0, 36'h0);
    checks++;
    if (acc_data !== {36'h0, 72'h0A0B0C0D0E0F101112}) begin
      errors++;
      $display("FAIL rst_next_window: got %h expected 0000000000A0B0C0D0E0F101112", acc_data);
    end
  endtask

  initial begin
    checks = 0; errors = 0;
    rst = 1'b1; kernel_load = 1'b0; kernel_in = '0;
    pix_valid = 1'b0; pix_data = '0; res_ready = 1'b0;
    acc_en = 1'b1; res_en = 1'b1;
    test_reset();
    test_basic();
    test_backpressure();
    test_kernel_same_cycle();
    test_timeout();
    test_rst_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
